// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchroniser, shared sample prescaler and
// per-bit stability counters, with one-cycle rise/fall strobes.
module sw_debounce #(
  parameter int n_sw   = 9,
  parameter int div    = 1000,
  parameter int stable = 4
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [n_sw-1:0] sw_raw,
  output logic [n_sw-1:0] sw,
  output logic [n_sw-1:0] sw_rise,
  output logic [n_sw-1:0] sw_fall,
  output logic            tick
);

  localparam int PW = (div > 1) ? $clog2(div) : 1;
  localparam int CW = (stable > 1) ? $clog2(stable + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(div - 1);
  localparam logic [CW:0]   STABLE_N = (CW + 1)'(stable);

  logic [n_sw-1:0] sync1;
  logic [n_sw-1:0] sync2;
  logic [PW-1:0]   pre;
  logic [CW-1:0]   cnt      [n_sw];
  logic [CW-1:0]   cnt_next [n_sw];
  logic [CW:0]     cnt_inc;
  logic [n_sw-1:0] sw_next;
  logic [n_sw-1:0] rise_next;
  logic [n_sw-1:0] fall_next;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // With div = 1 the counter sits at 0, which equals PRE_LAST, so tick stays high.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // A bit flips only after `stable` consecutive ticks that sample a differing level.
  always_comb begin
    cnt_inc   = '0;
    sw_next   = sw;
    rise_next = '0;
    fall_next = '0;
    for (int i = 0; i < n_sw; i++) begin
      cnt_next[i] = cnt[i];
      cnt_inc     = {1'b0, cnt[i]} + (CW + 1)'(1);
      if (tick) begin
        if (sync2[i] == sw[i]) begin
          cnt_next[i] = '0;
        end else if (cnt_inc < STABLE_N) begin
          cnt_next[i] = cnt_inc[CW-1:0];
        end else begin
          cnt_next[i]  = '0;
          sw_next[i]   = sync2[i];
          rise_next[i] = sync2[i];
          fall_next[i] = ~sync2[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sw      <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < n_sw; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw      <= sw_next;
      sw_rise <= rise_next;
      sw_fall <= fall_next;
      for (int i = 0; i < n_sw; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with div = 4, stable = 3; edge counts below
// are hand-derived from the synchroniser and prescaler timing.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [8:0] sw_raw = '0;
  logic [8:0] sw;
  logic [8:0] sw_rise;
  logic [8:0] sw_fall;
  logic       tick;

  int checks = 0;
  int errors = 0;

  int         obs_first_hit;
  int         obs_first_tick;
  int         obs_rise_pulses;
  int         obs_fall_pulses;
  int         obs_cnt0_bad;
  logic [8:0] obs_rise_at_hit;
  logic [8:0] obs_fall_at_hit;
  logic [8:0] obs_rise_or;
  logic [8:0] obs_fall_or;
  logic [8:0] obs_sw_or;

  sw_debounce #(.n_sw(9), .div(4), .stable(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .sw_raw  (sw_raw),
    .sw      (sw),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Samples n cycles at the falling edge; k counts rising edges since the call.
  task automatic observe(input int n, input logic [8:0] target);
    obs_first_hit   = -1;
    obs_first_tick  = -1;
    obs_rise_pulses = 0;
    obs_fall_pulses = 0;
    obs_cnt0_bad    = 0;
    obs_rise_at_hit = '0;
    obs_fall_at_hit = '0;
    obs_rise_or     = '0;
    obs_fall_or     = '0;
    obs_sw_or       = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (tick === 1'b1 && obs_first_tick < 0) obs_first_tick = k;
      if (sw === target && obs_first_hit < 0) begin
        obs_first_hit   = k;
        obs_rise_at_hit = sw_rise;
        obs_fall_at_hit = sw_fall;
      end
      if (sw_rise !== 9'h000) obs_rise_pulses++;
      if (sw_fall !== 9'h000) obs_fall_pulses++;
      obs_rise_or = obs_rise_or | sw_rise;
      obs_fall_or = obs_fall_or | sw_fall;
      obs_sw_or   = obs_sw_or | sw;
      if (dut.cnt[0] !== 2'd0) obs_cnt0_bad++;
    end
  endtask

  // Returns on the falling edge just before a tick-sampling rising edge.
  task automatic wait_tick;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_timeout: tick=%b required 1 within 8 cycles", tick);
    end
  endtask

  task automatic apply_reset(input logic [8:0] raw);
    n_reset = 1'b0;
    sw_raw  = raw;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    sw_raw  = 9'h1FF;
    repeat (3) @(negedge clk);
    checks++; if (sw !== 9'h000) begin errors++; $display("[TB] FAIL reset_sw: got %h required 000", sw); end
    checks++; if (sw_rise !== 9'h000) begin errors++; $display("[TB] FAIL reset_rise: got %h required 000", sw_rise); end
    checks++; if (sw_fall !== 9'h000) begin errors++; $display("[TB] FAIL reset_fall: got %h required 000", sw_fall); end
    checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b required 0", tick); end
    n_reset = 1'b1;
    observe(14, 9'h1FF);
    checks++; if (obs_first_tick !== 3) begin errors++; $display("[TB] FAIL first_tick: got edge %0d required 3", obs_first_tick); end
    checks++; if (obs_first_hit !== 12) begin errors++; $display("[TB] FAIL reset_release_sw: got edge %0d required 12", obs_first_hit); end
    checks++; if (obs_rise_at_hit !== 9'h1FF) begin errors++; $display("[TB] FAIL reset_release_rise: got %h required 1ff", obs_rise_at_hit); end
    checks++; if (obs_rise_pulses !== 1) begin errors++; $display("[TB] FAIL reset_release_rise_count: got %0d required 1", obs_rise_pulses); end
    checks++; if (obs_fall_pulses !== 0) begin errors++; $display("[TB] FAIL reset_release_fall_count: got %0d required 0", obs_fall_pulses); end
  endtask

  task automatic test_clean_change;
    apply_reset(9'h000);
    wait_tick;
    sw_raw = 9'h01E;
    observe(16, 9'h01E);
    checks++; if (obs_first_hit !== 13) begin errors++; $display("[TB] FAIL clean_latency: got edge %0d required 13", obs_first_hit); end
    checks++; if (obs_rise_at_hit !== 9'h01E) begin errors++; $display("[TB] FAIL clean_rise: got %h required 01e", obs_rise_at_hit); end
    checks++; if (obs_fall_or !== 9'h000) begin errors++; $display("[TB] FAIL clean_fall: got %h required 000", obs_fall_or); end
    checks++; if (obs_rise_pulses !== 1) begin errors++; $display("[TB] FAIL clean_rise_count: got %0d required 1", obs_rise_pulses); end
    checks++; if (sw !== 9'h01E) begin errors++; $display("[TB] FAIL clean_final_sw: got %h required 01e", sw); end
  endtask

  task automatic test_mixed_edges;
    wait_tick;
    sw_raw = 9'h0FD;
    observe(16, 9'h0FD);
    checks++; if (obs_first_hit !== 13) begin errors++; $display("[TB] FAIL mixed_latency: got edge %0d required 13", obs_first_hit); end
    checks++; if (obs_rise_at_hit !== 9'h0E1) begin errors++; $display("[TB] FAIL mixed_rise: got %h required 0e1", obs_rise_at_hit); end
    checks++; if (obs_fall_at_hit !== 9'h002) begin errors++; $display("[TB] FAIL mixed_fall: got %h required 002", obs_fall_at_hit); end
    checks++; if (obs_rise_pulses !== 1 || obs_fall_pulses !== 1) begin errors++; $display("[TB] FAIL mixed_pulse_count: got rise %0d fall %0d required 1 and 1", obs_rise_pulses, obs_fall_pulses); end
    checks++; if (sw !== 9'h0FD) begin errors++; $display("[TB] FAIL mixed_final_sw: got %h required 0fd", sw); end
  endtask

  task automatic test_bounce;
    logic [8:0] bounce_rise;
    logic [8:0] bounce_fall;
    logic [8:0] bounce_sw;
    bounce_rise = '0;
    bounce_fall = '0;
    bounce_sw   = '0;
    for (int p = 0; p < 8; p++) begin
      sw_raw[8] = (p % 2 == 0);
      observe(5, 9'h1FD);
      bounce_rise = bounce_rise | obs_rise_or;
      bounce_fall = bounce_fall | obs_fall_or;
      bounce_sw   = bounce_sw | obs_sw_or;
    end
    checks++; if (bounce_sw[8] !== 1'b0) begin errors++; $display("[TB] FAIL bounce_sw8: got %b required 0", bounce_sw[8]); end
    checks++; if (bounce_rise !== 9'h000 || bounce_fall !== 9'h000) begin errors++; $display("[TB] FAIL bounce_pulses: got rise %h fall %h required 000 and 000", bounce_rise, bounce_fall); end
    sw_raw[8] = 1'b1;
    observe(20, 9'h1FD);
    checks++; if (obs_first_hit < 11 || obs_first_hit > 14) begin errors++; $display("[TB] FAIL settle_latency: got edge %0d required 11..14", obs_first_hit); end
    checks++; if (obs_rise_pulses !== 1 || obs_rise_or !== 9'h100) begin errors++; $display("[TB] FAIL settle_rise: got %0d pulses mask %h required 1 pulse mask 100", obs_rise_pulses, obs_rise_or); end
    checks++; if (obs_fall_pulses !== 0) begin errors++; $display("[TB] FAIL settle_fall: got %0d required 0", obs_fall_pulses); end
    checks++; if (sw !== 9'h1FD) begin errors++; $display("[TB] FAIL settle_final_sw: got %h required 1fd", sw); end
  endtask

  task automatic test_glitch;
    apply_reset(9'h000);
    wait_tick;
    @(negedge clk);
    sw_raw[0] = 1'b1;
    @(negedge clk);
    sw_raw[0] = 1'b0;
    observe(16, 9'h000);
    checks++; if (obs_sw_or !== 9'h000) begin errors++; $display("[TB] FAIL glitch_sw: got %h required 000", obs_sw_or); end
    checks++; if (obs_rise_or !== 9'h000 || obs_fall_or !== 9'h000) begin errors++; $display("[TB] FAIL glitch_pulses: got rise %h fall %h required 000 and 000", obs_rise_or, obs_fall_or); end
    checks++; if (obs_cnt0_bad !== 0) begin errors++; $display("[TB] FAIL glitch_cnt0: got %0d nonzero cycles required 0", obs_cnt0_bad); end
  endtask

  task automatic test_reset_mid_count;
    wait_tick;
    sw_raw = 9'h008;
    repeat (9) @(negedge clk);
    checks++; if (dut.cnt[3] !== 2'd2) begin errors++; $display("[TB] FAIL midcount_cnt3: got %0d required 2", dut.cnt[3]); end
    n_reset = 1'b0;
    #1;
    checks++; if (dut.cnt[3] !== 2'd0) begin errors++; $display("[TB] FAIL midcount_async_clear: got %0d required 0", dut.cnt[3]); end
    repeat (2) @(negedge clk);
    checks++; if (sw !== 9'h000 || sw_rise !== 9'h000) begin errors++; $display("[TB] FAIL midcount_reset_out: got sw %h rise %h required 000 and 000", sw, sw_rise); end
    n_reset = 1'b1;
    observe(16, 9'h008);
    checks++; if (obs_first_hit !== 12) begin errors++; $display("[TB] FAIL midcount_fresh_latency: got edge %0d required 12", obs_first_hit); end
    checks++; if (obs_rise_at_hit !== 9'h008 || obs_rise_pulses !== 1) begin errors++; $display("[TB] FAIL midcount_rise: got %h x%0d required 008 x1", obs_rise_at_hit, obs_rise_pulses); end
    checks++; if (obs_fall_pulses !== 0) begin errors++; $display("[TB] FAIL midcount_fall: got %0d required 0", obs_fall_pulses); end
  endtask

  initial begin
    test_reset;
    test_clean_change;
    test_mixed_edges;
    test_bounce;
    test_glitch;
    test_reset_mid_count;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
